design_20_drv: RTL and testbench

Initiator-side driver for the design_20 start/a/b → y/valid operand interface. It accepts operand-pair commands from an upstream ready/valid channel and issues each one to the datapath as a `start` pulse with held operands. It waits for the returning `valid`, captures `y` into a 4-entry result FIFO, and presents results downstream on a second ready/valid channel. It sits between a test/sequencer fabric and the design_20 instance, one driver per instance.

---
 rtl/design_20_drv_if.sv | 43 ++++
 rtl/design_20_drv.sv | 197 +++++++++++++++++++
 tb/tb_design_20_drv.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/design_20_drv_if.sv
// design_20_drv_if
// Bundles the three channels the design_20 driver talks on:
//   cmd : upstream operand-pair commands (cmd_valid/cmd_ready, cmd_a, cmd_b)
//   dut : datapath side (dut_start, dut_a, dut_b out; dut_y, dut_valid in)
//   res : downstream results (res_valid/res_ready, res_y, res_err)
// master = driver view, slave = environment (sequencer + datapath) view.
interface design_20_drv_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_ready;

    logic         dut_start;
    logic [W-1:0] dut_a;
    logic [W-1:0] dut_b;
    logic [W-1:0] dut_y;
    logic         dut_valid;

    logic         res_valid;
    logic [W-1:0] res_y;
    logic         res_err;
    logic         res_ready;

    modport master (
        input  cmd_valid, cmd_a, cmd_b,
        output cmd_ready,
        output dut_start, dut_a, dut_b,
        input  dut_y, dut_valid,
        output res_valid, res_y, res_err,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b,
        input  cmd_ready,
        input  dut_start, dut_a, dut_b,
        output dut_y, dut_valid,
        input  res_valid, res_y, res_err,
        output res_ready
    );
endinterface

// File: rtl/design_20_drv.sv
// design_20_drv
// Initiator-side driver for one design_20 datapath instance. Accepts operand
// pairs, issues each as a one-cycle start pulse with held operands, waits for
// the returning valid and queues the result in a 4-entry FIFO for downstream.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   bus          design_20_drv_if.master (cmd / dut / res channels)
//   o_busy       FSM not in IDLE
//   o_stray_cnt  dut_valid pulses seen outside WAIT, saturating at 255
//
// Optional feature: define DESIGN_20_DRV_TIMEOUT_EN to give up on a silent
// datapath after TO_CYC WAIT cycles and queue an error entry {err=1, y=0}.
// Without it WAIT lasts until dut_valid and res_err is tied low.
//
// state   | meaning
// IDLE    | ready for a command when the FIFO has room
// ISSUE   | dut_start high for this single cycle
// WAIT    | waiting for dut_valid (or timeout when enabled)
module design_20_drv #(
    parameter int W      = 8,
    parameter int TO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    design_20_drv_if.master bus,
    output logic            o_busy,
    output logic [7:0]      o_stray_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    if (TO_CYC < 2 || TO_CYC > 255) begin : g_bad_to_cyc
        $error("design_20_drv: TO_CYC must lie in 2..255");
    end

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_cmd_ready;
    logic         w_accept;
    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_push_y;

    logic [W-1:0] r_dut_a;
    logic [W-1:0] r_dut_b;
    logic         r_dut_start;
    logic [7:0]   r_stray_cnt;

    logic [W-1:0] r_mem_y [4];
    logic [1:0]   r_wr_ptr;
    logic [1:0]   r_rd_ptr;
    logic [2:0]   r_count;

`ifdef DESIGN_20_DRV_TIMEOUT_EN
    logic         w_timeout;
    logic         w_push_err;
    logic [7:0]   r_to_cnt;
    logic         r_mem_err [4];

    // Counter is 0 in the first WAIT cycle, so TO_CYC-1 marks the last one.
    assign w_timeout = (r_to_cnt == 8'(TO_CYC - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
`ifdef DESIGN_20_DRV_TIMEOUT_EN
        w_push_err  = 1'b0;
`endif
        // A slot is effectively reserved here: count can only fall while a
        // command is in flight, so the eventual push always finds room.
        w_cmd_ready = (r_state == S_IDLE) && (r_count < 3'd4);
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && w_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A valid arriving on the timeout cycle still wins.
                if (bus.dut_valid) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`ifdef DESIGN_20_DRV_TIMEOUT_EN
                else if (w_timeout) begin
                    w_push      = 1'b1;
                    w_push_err  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dut_a     <= '0;
            r_dut_b     <= '0;
            r_dut_start <= 1'b0;
            r_stray_cnt <= 8'd0;
        end else begin
            r_dut_start <= w_accept;
            if (w_accept) begin
                r_dut_a <= bus.cmd_a;
                r_dut_b <= bus.cmd_b;
            end
            if (bus.dut_valid && (r_state != S_WAIT) && (r_stray_cnt != 8'hFF)) begin
                r_stray_cnt <= r_stray_cnt + 8'd1;
            end
        end
    end

`ifdef DESIGN_20_DRV_TIMEOUT_EN
    assign w_push_y = w_push_err ? '0 : bus.dut_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_to_cnt <= 8'd0;
        end else if (r_state == S_WAIT) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_mem_err[i] <= 1'b0;
        end else if (w_push) begin
            r_mem_err[r_wr_ptr] <= w_push_err;
        end
    end

    assign bus.res_err = r_mem_err[r_rd_ptr];
`else
    assign w_push_y    = bus.dut_y;
    assign bus.res_err = 1'b0;
`endif

    assign w_pop = (r_count != 3'd0) && bus.res_ready;

    // Storage is cleared on reset so the head reads 0 while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_mem_y[i] <= '0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem_y[r_wr_ptr] <= w_push_y;
                r_wr_ptr          <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.dut_start = r_dut_start;
    assign bus.dut_a     = r_dut_a;
    assign bus.dut_b     = r_dut_b;
    assign bus.res_valid = (r_count != 3'd0);
    assign bus.res_y     = r_mem_y[r_rd_ptr];
    assign o_busy        = (r_state != S_IDLE);
    assign o_stray_cnt   = r_stray_cnt;

endmodule

// File: tb/tb_design_20_drv.sv
// tb_design_20_drv
// Self-checking bench for design_20_drv. A reference model tracks the driver
// as "command in flight with age", a result queue and a stray tally; every
// cycle the DUT outputs are compared against it. Directed scenarios cover
// single command, back-pressure, push/pop at count 1, stray saturation,
// timeout (when DESIGN_20_DRV_TIMEOUT_EN is defined) and reset mid-WAIT,
// followed by a long randomized run.
module tb_design_20_drv;
    localparam int W      = 8;
    localparam int TO_CYC = 16;
`ifdef DESIGN_20_DRV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy;
    logic [7:0] stray;

    design_20_drv_if #(.W(W)) bus ();

    design_20_drv #(.W(W), .TO_CYC(TO_CYC)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_busy      (busy),
        .o_stray_cnt (stray)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model
    logic [W:0]   m_q [$];
    bit           m_busy;
    int           m_age;
    int           m_lat;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           m_stray;
    int           n_start;

    // random stimulus knobs (percentages / latency range)
    int k_cmd     = 50;
    int k_rdy     = 50;
    int k_stray   = 0;
    int k_lat_min = 1;
    int k_lat_max = 3;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy && m_q.size() < 4));
        check("dut_start", 32'(bus.dut_start), 32'(m_busy && m_age == 1));
        check("dut_a", 32'(bus.dut_a), 32'(m_a));
        check("dut_b", 32'(bus.dut_b), 32'(m_b));
        check("res_valid", 32'(bus.res_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("res_y", 32'(bus.res_y), 32'(m_q[0][W-1:0]));
            check("res_err", 32'(bus.res_err), 32'(m_q[0][W]));
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("stray_cnt", 32'(stray), 32'(m_stray));
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit ready;
        bit in_wait;
        bit done;
        ready   = !m_busy && (m_q.size() < 4);
        in_wait = m_busy && (m_age >= 2);
        done    = 1'b0;
        if (bus.dut_start === 1'b1) n_start++;
        if (bus.dut_valid && !in_wait && m_stray < 255) m_stray++;
        if (m_q.size() != 0 && bus.res_ready) void'(m_q.pop_front());
        if (in_wait) begin
            if (bus.dut_valid) begin
                m_q.push_back({1'b0, bus.dut_y});
                done = 1'b1;
            end else if (TO_EN && m_age == TO_CYC + 1) begin
                m_q.push_back({1'b1, {W{1'b0}}});
                done = 1'b1;
            end
        end
        if (done) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_age++;
        end else if (ready && bus.cmd_valid) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_a    = bus.cmd_a;
            m_b    = bus.cmd_b;
            m_lat  = int'($urandom_range(k_lat_max, k_lat_min));
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic dv, input logic [W-1:0] y, input logic rr);
        bus.cmd_valid = cv;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.dut_valid = dv;
        bus.dut_y     = y;
        bus.res_ready = rr;
        cycle();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            bus.cmd_valid = ($urandom_range(99) < 32'(k_cmd));
            bus.cmd_a     = W'($urandom);
            bus.cmd_b     = W'($urandom);
            bus.res_ready = ($urandom_range(99) < 32'(k_rdy));
            if (m_busy && m_age >= 1 + m_lat) begin
                bus.dut_valid = 1'b1;
                bus.dut_y     = m_a + m_b;
            end else if ($urandom_range(99) < 32'(k_stray)) begin
                bus.dut_valid = 1'b1;
                bus.dut_y     = W'($urandom);
            end else begin
                bus.dut_valid = 1'b0;
                bus.dut_y     = '0;
            end
            cycle();
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.dut_valid = 1'b0;
        bus.dut_y     = '0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_dut_start", 32'(bus.dut_start), 32'd0);
        check("rst_dut_a", 32'(bus.dut_a), 32'd0);
        check("rst_dut_b", 32'(bus.dut_b), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_y", 32'(bus.res_y), 32'd0);
        check("rst_res_err", 32'(bus.res_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stray", 32'(stray), 32'd0);
        m_q.delete();
        m_busy  = 1'b0;
        m_age   = 0;
        m_a     = '0;
        m_b     = '0;
        m_stray = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // single command, result two cycles after start
        n_start = 0;
        drive(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0);
        check("single_start_hi", 32'(bus.dut_start), 32'd1);
        check("single_dut_a", 32'(bus.dut_a), 32'h12);
        check("single_dut_b", 32'(bus.dut_b), 32'h34);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h46, 1'b0);
        check("single_res_valid", 32'(bus.res_valid), 32'd1);
        check("single_res_y", 32'(bus.res_y), 32'h46);
        check("single_res_err", 32'(bus.res_err), 32'd0);
        check("single_one_pulse", 32'(n_start), 32'd1);
        check("single_a_held", 32'(bus.dut_a), 32'h12);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);

        // stray: 3 in IDLE, 1 in ISSUE
        repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b1, W'($urandom), 1'b0);
        drive(1'b1, 8'h21, 8'h43, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h99, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h64, 1'b0);
        check("stray_four", 32'(stray), 32'd4);
        check("stray_res_y", 32'(bus.res_y), 32'h64);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (300) drive(1'b0, 8'h00, 8'h00, 1'b1, W'($urandom), 1'b0);
        check("stray_sat", 32'(stray), 32'd255);

        // back-pressure: 4 results fill the FIFO, 5th held off
        do_reset();
        n_start = 0;
        k_cmd = 100; k_rdy = 0; k_stray = 0; k_lat_min = 1; k_lat_max = 3;
        run(30);
        check("bp_starts", 32'(n_start), 32'd4);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("bp_full", 32'(bus.res_valid), 32'd1);
        k_rdy = 100;
        run(30);
        check("bp_fifth_issued", 32'(n_start > 4), 32'd1);
        k_cmd = 0;
        run(20);

        // push and pop on the same edge at count 1
        drive(1'b1, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 1'b0);
        drive(1'b1, 8'h05, 8'h06, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h0B, 1'b1);
        check("pp_valid", 32'(bus.res_valid), 32'd1);
        check("pp_head", 32'(bus.res_y), 32'h0B);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        check("pp_drained", 32'(bus.res_valid), 32'd0);

`ifdef DESIGN_20_DRV_TIMEOUT_EN
        // silent datapath times out after TO_CYC WAIT cycles
        drive(1'b1, 8'h05, 8'h06, 1'b0, 8'h00, 1'b0);
        repeat (1 + TO_CYC) drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        check("to_valid", 32'(bus.res_valid), 32'd1);
        check("to_err", 32'(bus.res_err), 32'd1);
        check("to_y", 32'(bus.res_y), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        // valid on the last WAIT cycle wins over the timeout
        drive(1'b1, 8'h07, 8'h08, 1'b0, 8'h00, 1'b0);
        repeat (TO_CYC) drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0);
        check("to_race_err", 32'(bus.res_err), 32'd0);
        check("to_race_y", 32'(bus.res_y), 32'h5A);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
`endif

        // randomized traffic
        k_cmd = 60; k_rdy = 50; k_stray = 3; k_lat_min = 1;
        k_lat_max = TO_EN ? TO_CYC + 4 : 6;
        run(3000);

        // drain, then reset while in WAIT with 2 results queued
        k_cmd = 0; k_rdy = 100; k_stray = 0;
        run(40);
        drive(1'b1, 8'h10, 8'h01, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h20, 8'h02, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h30, 8'h03, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rw_busy_before", 32'(busy), 32'd1);
        do_reset();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 1'b0);
        check("rw_stray_one", 32'(stray), 32'd1);
        drive(1'b1, 8'h40, 8'h04, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h44, 1'b0);
        check("rw_after_valid", 32'(bus.res_valid), 32'd1);
        check("rw_after_y", 32'(bus.res_y), 32'h44);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
